trig_cmd_sequencer: RTL and testbench
=====================================

TRIG_CMD_SEQUENCER -- requirements
Module: trig_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter NCH, default 8, giving the number of downstream trigger/LED channels supervised.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the number of program-table entries (power of two).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-004 The block SHALL have these table write ports: wr_en in 1; wr_addr in log2(DEPTH); wr_duration in 16; wr_delay in 16; wr_last in 1 (end-of-program flag).
REQ-005 The block SHALL have these control ports: start in 1 (run pulse); abort in 1 (stop pulse); loop_count in 8 (extra passes).
REQ-006 The block SHALL have these channel status inputs: chan_active in NCH (per-channel isActive mirror); chan_complete in NCH (per-channel trigLedComplete).
REQ-007 The block SHALL have these channel drive outputs: onYourMark out 1; GOGOGO_EXCLAMATION out 1; duration out 16; delay out 16; hardStop out 1.
REQ-008 The block SHALL have these status outputs: busy out 1; done out 1 (one-cycle pulse); step_idx out log2(DEPTH).

Function
REQ-009 The FSM SHALL have the states IDLE, FETCH, MARK, GO, WAIT, NEXT, ABORT.
REQ-010 IDLE: busy=0; start -> FETCH with step_idx=0 and pass counter=0.
REQ-011 FETCH: the registered table read of entry step_idx SHALL complete in one cycle; next state MARK.
REQ-012 MARK: onYourMark=1, GOGOGO=0 for exactly one cycle; duration and delay driven from the entry from MARK through WAIT; next state GO.
REQ-013 GO: onYourMark=1 and GOGOGO=1 for exactly one cycle; next state WAIT; first GOGOGO rising edge SHALL occur 3 cycles after start is sampled.
REQ-014 WAIT: both strobes low; chan_complete SHALL be ignored for a 3-cycle guard, then the FSM SHALL wait until &(chan_complete | ~chan_active) = 1, then go to NEXT.
REQ-015 With chan_active all zero, WAIT SHALL exit right after the guard.
REQ-016 NEXT: if the entry has wr_last=1 or step_idx=DEPTH-1, the pass ends; otherwise step_idx increments and the FSM goes to FETCH.
REQ-017 At pass end, the block SHALL pulse done for one cycle and return to IDLE, unless loop repeat applies (REQ-024).
REQ-018 start while busy SHALL be ignored.
REQ-019 wr_en while busy SHALL be ignored, and the table SHALL be unchanged.
REQ-020 abort in any non-IDLE state -> ABORT: both strobes low, hardStop=1 for exactly 2 cycles, then IDLE with no done pulse; abort in IDLE SHALL be ignored.
REQ-021 start and abort sampled in the same IDLE cycle: abort SHALL win and no run SHALL start.

Reset
REQ-022 On rst: state=IDLE; onYourMark, GOGOGO_EXCLAMATION, hardStop, busy, done=0; duration, delay, step_idx=0; pass counter=0.
REQ-023 Table contents SHALL NOT be cleared by rst; reset mid-run SHALL take effect the next cycle with no done pulse.

Configuration
REQ-024 With macro TRIG_SEQ_LOOP_EN defined: at pass end, if pass counter < loop_count, the counter SHALL increment, step_idx=0, and the FSM SHALL go to FETCH; total passes = loop_count+1.
REQ-025 Without TRIG_SEQ_LOOP_EN: the loop_count port SHALL remain present but be ignored, and exactly one pass SHALL run.

Structure
REQ-026 The shared package trig_seq_pkg SHALL hold the FSM state encoding, the 16-bit duration/delay width constant, and the guard length constant (3).
REQ-027 The program table SHALL be the sub-module trig_seq_table (DEPTH x 33-bit register file, one write port, one registered read port).

Verification
REQ-028 One-entry program (dur=5, del=2, last), chan_active=0x01 -> MARK pulse, then GO pulse at cycle 3; done after chan_complete[0] rises.
REQ-029 Three entries, third last, chan_active=0xFF, completes staggered -> each WAIT exits only on the cycle after the last active complete; step_idx runs 0,1,2.
REQ-030 abort during WAIT of entry 1 -> hardStop high for 2 cycles, no done, busy=0 afterwards, next start begins at step_idx=0.
REQ-031 TRIG_SEQ_LOOP_EN with loop_count=2 and a two-entry program -> 6 GO pulses, one done pulse; without the macro -> 2 GO pulses.
REQ-032 start+abort in the same cycle, start while busy, and wr_en while busy -> no run, run unaffected, and table unchanged, respectively.
REQ-033 rst asserted in GO -> all outputs 0 next cycle; a rerun without rewriting the table reproduces the original output sequence.

Source files
------------

// File: rtl/trig_seq_pkg.sv
// Shared types and constants for the trigger command sequencer.
package trig_seq_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned GUARD_LEN = 3;
    localparam int unsigned GUARD_W   = $clog2(GUARD_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_MARK  = 3'd2,
        S_GO    = 3'd3,
        S_WAIT  = 3'd4,
        S_NEXT  = 3'd5,
        S_ABORT = 3'd6
    } seq_state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] duration;
        logic [DATA_W-1:0] delay;
    } seq_entry_t;

    localparam int unsigned ENTRY_W = $bits(seq_entry_t);

endpackage

// File: rtl/trig_seq_table.sv
// Program table: DEPTH x 33-bit register file, one write port, one registered read port.
module trig_seq_table
    import trig_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  seq_entry_t               i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output seq_entry_t               o_rd_data
);

    seq_entry_t r_mem [DEPTH];
    seq_entry_t r_rd_data;

    // Contents are deliberately not reset so a program survives rst.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/trig_cmd_sequencer.sv
// Steps a programmed table of trigger commands across NCH channels.
// Optional macro TRIG_SEQ_LOOP_EN enables repeating the program loop_count extra times.
module trig_cmd_sequencer
    import trig_seq_pkg::*;
#(
    parameter int unsigned NCH   = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_duration,
    input  logic [DATA_W-1:0]        wr_delay,
    input  logic                     wr_last,
    input  logic                     start,
    input  logic                     abort,
    input  logic [7:0]               loop_count,
    input  logic [NCH-1:0]           chan_active,
    input  logic [NCH-1:0]           chan_complete,
    output logic                     onYourMark,
    output logic                     GOGOGO_EXCLAMATION,
    output logic [DATA_W-1:0]        duration,
    output logic [DATA_W-1:0]        delay,
    output logic                     hardStop,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] step_idx
);

    localparam int unsigned AW = $clog2(DEPTH);

    seq_state_t           r_state;
    seq_state_t           w_state_nxt;
    logic [AW-1:0]        r_step_idx;
    logic [AW-1:0]        w_step_nxt;
    logic [GUARD_W-1:0]   r_guard_cnt;
    logic [GUARD_W-1:0]   w_guard_nxt;
    logic                 r_abort_cnt;
    logic                 w_abort_nxt;
    logic                 r_last;
    logic                 w_done_nxt;
    logic                 w_pass_end;
    logic                 w_all_done;
    logic                 w_tbl_wr;
    seq_entry_t           w_wr_data;
    seq_entry_t           w_rd_data;

    logic                 r_on_your_mark;
    logic                 r_gogo;
    logic [DATA_W-1:0]    r_duration;
    logic [DATA_W-1:0]    r_delay;
    logic                 r_hard_stop;
    logic                 r_busy;
    logic                 r_done;

`ifdef TRIG_SEQ_LOOP_EN
    logic [7:0]           r_pass_cnt;
    logic [7:0]           w_pass_nxt;
`else
    logic                 w_unused_loop;
    assign w_unused_loop = ^loop_count;
`endif

    // Writes only land while idle so a running program cannot be corrupted.
    assign w_tbl_wr           = wr_en && (r_state == S_IDLE);
    assign w_wr_data.last     = wr_last;
    assign w_wr_data.duration = wr_duration;
    assign w_wr_data.delay    = wr_delay;

    // Read address follows the next step so the entry is ready during FETCH.
    trig_seq_table #(
        .DEPTH (DEPTH)
    ) u_table (
        .clk       (clk),
        .i_wr_en   (w_tbl_wr),
        .i_wr_addr (wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (w_step_nxt),
        .o_rd_data (w_rd_data)
    );

    // Inactive channels count as complete.
    assign w_all_done = &(chan_complete | ~chan_active);

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step_idx;
        w_guard_nxt = r_guard_cnt;
        w_abort_nxt = r_abort_cnt;
        w_done_nxt  = 1'b0;
        w_pass_end  = r_last || (r_step_idx == AW'(DEPTH - 1));
`ifdef TRIG_SEQ_LOOP_EN
        w_pass_nxt  = r_pass_cnt;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = S_FETCH;
                    w_step_nxt  = '0;
`ifdef TRIG_SEQ_LOOP_EN
                    w_pass_nxt  = '0;
`endif
                end
            end
            S_FETCH: w_state_nxt = S_MARK;
            S_MARK:  w_state_nxt = S_GO;
            S_GO: begin
                w_state_nxt = S_WAIT;
                w_guard_nxt = '0;
            end
            S_WAIT: begin
                if (r_guard_cnt != GUARD_W'(GUARD_LEN)) begin
                    w_guard_nxt = r_guard_cnt + GUARD_W'(1);
                end else if (w_all_done) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                if (!w_pass_end) begin
                    w_step_nxt  = r_step_idx + AW'(1);
                    w_state_nxt = S_FETCH;
                end
`ifdef TRIG_SEQ_LOOP_EN
                else if (r_pass_cnt < loop_count) begin
                    w_pass_nxt  = r_pass_cnt + 8'd1;
                    w_step_nxt  = '0;
                    w_state_nxt = S_FETCH;
                end
`endif
                else begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            S_ABORT: begin
                w_abort_nxt = 1'b1;
                if (r_abort_cnt) begin
                    w_state_nxt = S_IDLE;
                    w_abort_nxt = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (abort && (r_state != S_IDLE) && (r_state != S_ABORT)) begin
            w_state_nxt = S_ABORT;
            w_abort_nxt = 1'b0;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_step_idx  <= '0;
            r_guard_cnt <= '0;
            r_abort_cnt <= 1'b0;
            r_last      <= 1'b0;
`ifdef TRIG_SEQ_LOOP_EN
            r_pass_cnt  <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_step_idx  <= w_step_nxt;
            r_guard_cnt <= w_guard_nxt;
            r_abort_cnt <= w_abort_nxt;
`ifdef TRIG_SEQ_LOOP_EN
            r_pass_cnt  <= w_pass_nxt;
`endif
            if (r_state == S_FETCH) begin
                r_last <= w_rd_data.last;
            end
        end
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_on_your_mark <= 1'b0;
            r_gogo         <= 1'b0;
            r_hard_stop    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_duration     <= '0;
            r_delay        <= '0;
        end else begin
            r_on_your_mark <= (w_state_nxt == S_MARK) || (w_state_nxt == S_GO);
            r_gogo         <= (w_state_nxt == S_GO);
            r_hard_stop    <= (w_state_nxt == S_ABORT);
            r_busy         <= (w_state_nxt != S_IDLE);
            r_done         <= w_done_nxt;
            if (w_state_nxt == S_MARK) begin
                r_duration <= w_rd_data.duration;
                r_delay    <= w_rd_data.delay;
            end else if (!(w_state_nxt inside {S_GO, S_WAIT})) begin
                r_duration <= '0;
                r_delay    <= '0;
            end
        end
    end

    assign onYourMark         = r_on_your_mark;
    assign GOGOGO_EXCLAMATION = r_gogo;
    assign duration           = r_duration;
    assign delay              = r_delay;
    assign hardStop           = r_hard_stop;
    assign busy               = r_busy;
    assign done               = r_done;
    assign step_idx           = r_step_idx;

endmodule

// File: tb/tb_trig_cmd_sequencer.sv
// Randomized self-checking bench for trig_cmd_sequencer; expected traces are
// assembled phase by phase from the program table and channel completion times.
module tb_trig_cmd_sequencer;

    localparam int unsigned NCH   = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int          GUARD = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [15:0]      wr_duration;
    logic [15:0]      wr_delay;
    logic             wr_last;
    logic             start;
    logic             abort;
    logic [7:0]       loop_count;
    logic [NCH-1:0]   chan_active;
    logic [NCH-1:0]   chan_complete;
    logic             on_your_mark;
    logic             gogo;
    logic [15:0]      duration;
    logic [15:0]      delay;
    logic             hard_stop;
    logic             busy;
    logic             done;
    logic [AW-1:0]    step_idx;

    trig_cmd_sequencer #(.NCH(NCH), .DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .wr_en              (wr_en),
        .wr_addr            (wr_addr),
        .wr_duration        (wr_duration),
        .wr_delay           (wr_delay),
        .wr_last            (wr_last),
        .start              (start),
        .abort              (abort),
        .loop_count         (loop_count),
        .chan_active        (chan_active),
        .chan_complete      (chan_complete),
        .onYourMark         (on_your_mark),
        .GOGOGO_EXCLAMATION (gogo),
        .duration           (duration),
        .delay              (delay),
        .hardStop           (hard_stop),
        .busy               (busy),
        .done               (done),
        .step_idx           (step_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          mark;
        logic          go;
        logic [15:0]   dur;
        logic [15:0]   del;
        logic          hs;
        logic          bsy;
        logic          dn;
        logic [AW-1:0] step;
    } obs_t;

    typedef struct packed {
        logic           start;
        logic           abort;
        logic           rst;
        logic [NCH-1:0] comp;
    } drv_t;

    obs_t          exp_q[$];
    obs_t          obs_q[$];
    drv_t          drv_q[$];
    logic [15:0]   m_dur [DEPTH];
    logic [15:0]   m_del [DEPTH];
    bit            m_last[DEPTH];
    int            off   [DEPTH][NCH];
    logic [AW-1:0] m_step;
    bit            junk;
    int            tests;
    int            fails;

    function automatic obs_t mk(input logic mk_mark, input logic mk_go,
                                input logic [15:0] mk_dur, input logic [15:0] mk_del,
                                input logic mk_hs, input logic mk_bsy, input logic mk_dn,
                                input logic [AW-1:0] mk_step);
        obs_t o;
        o.mark = mk_mark; o.go = mk_go; o.dur = mk_dur; o.del = mk_del;
        o.hs = mk_hs; o.bsy = mk_bsy; o.dn = mk_dn; o.step = mk_step;
        return o;
    endfunction

    function automatic drv_t rnd_drv();
        drv_t d;
        d = '0;
        d.comp = NCH'($urandom);
        return d;
    endfunction

    function automatic int passes_for(input int lc);
`ifdef TRIG_SEQ_LOOP_EN
        return lc + 1;
`else
        return (lc >= 0) ? 1 : 1;
`endif
    endfunction

    // WAIT lasts until the guard has elapsed and every active channel has completed.
    function automatic int wait_len(input int s);
        int e;
        e = GUARD;
        for (int i = 0; i < NCH; i++)
            if (chan_active[i] && off[s][i] > e) e = off[s][i];
        return e + 1;
    endfunction

    task automatic write_entry(input int s, input logic [15:0] d, input logic [15:0] l, input bit last);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = AW'(s); wr_duration = d; wr_delay = l; wr_last = last;
        m_dur[s] = d; m_del[s] = l; m_last[s] = last;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic load_prog(input int n, input bit with_last);
        for (int s = 0; s < n; s++)
            write_entry(s, 16'($urandom), 16'($urandom), with_last && (s == n - 1));
    endtask

    task automatic set_off(input int maxo);
        for (int s = 0; s < DEPTH; s++)
            for (int i = 0; i < NCH; i++) off[s][i] = $urandom_range(maxo, 0);
    endtask

    task automatic build_trace(input int passes);
        int   plen;
        drv_t d;
        logic [AW-1:0] st;
        exp_q.delete(); drv_q.delete();
        plen = DEPTH;
        for (int s = DEPTH - 1; s >= 0; s--) if (m_last[s]) plen = s + 1;
        d = rnd_drv(); d.start = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, m_step)); drv_q.push_back(d);
        for (int p = 0; p < passes; p++) begin
            for (int s = 0; s < plen; s++) begin
                st = AW'(s);
                exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, st));               drv_q.push_back(rnd_drv());
                exp_q.push_back(mk(1, 0, m_dur[s], m_del[s], 0, 1, 0, st)); drv_q.push_back(rnd_drv());
                exp_q.push_back(mk(1, 1, m_dur[s], m_del[s], 0, 1, 0, st)); drv_q.push_back(rnd_drv());
                for (int w = 0; w < wait_len(s); w++) begin
                    d = '0;
                    for (int i = 0; i < NCH; i++) begin
                        if (!chan_active[i])       d.comp[i] = 1'($urandom);
                        else if (w >= off[s][i])   d.comp[i] = 1'b1;
                        else if (w < GUARD)        d.comp[i] = 1'($urandom);
                        else                       d.comp[i] = 1'b0;
                    end
                    exp_q.push_back(mk(0, 0, m_dur[s], m_del[s], 0, 1, 0, st)); drv_q.push_back(d);
                end
                exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, st));               drv_q.push_back(rnd_drv());
            end
        end
        m_step = AW'(plen - 1);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, m_step)); drv_q.push_back(rnd_drv());
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, m_step)); drv_q.push_back(rnd_drv());
    endtask

    task automatic apply_abort(input int a);
        drv_t d;
        logic [AW-1:0] st;
        st = exp_q[a].step;
        while (exp_q.size() > a + 1) void'(exp_q.pop_back());
        while (drv_q.size() > a + 1) void'(drv_q.pop_back());
        d = drv_q[a]; d.abort = 1'b1; drv_q[a] = d;
        repeat (2) begin exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 0, st)); drv_q.push_back(rnd_drv()); end
        repeat (2) begin exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, st)); drv_q.push_back(rnd_drv()); end
        m_step = st;
    endtask

    task automatic apply_rst(input int r);
        drv_t d;
        while (exp_q.size() > r + 1) void'(exp_q.pop_back());
        while (drv_q.size() > r + 1) void'(drv_q.pop_back());
        d = drv_q[r]; d.rst = 1'b1; drv_q[r] = d;
        repeat (2) begin exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, '0)); drv_q.push_back(rnd_drv()); end
        m_step = '0;
    endtask

    // Drives one interval per clock and samples the outputs mid-cycle.
    task automatic run_trace();
        drv_t d;
        obs_t o;
        obs_q.delete();
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk); #1;
            d = drv_q[k];
            start = d.start; abort = d.abort; rst = d.rst; chan_complete = d.comp;
            wr_en = 1'b0;
            if (junk && exp_q[k].bsy) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = AW'($urandom);
                wr_duration = 16'($urandom); wr_delay = 16'($urandom); wr_last = 1'($urandom);
            end
            @(negedge clk);
            o.mark = on_your_mark; o.go = gogo; o.dur = duration; o.del = delay;
            o.hs = hard_stop; o.bsy = busy; o.dn = done; o.step = step_idx;
            obs_q.push_back(o);
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            o.mark = on_your_mark; o.go = gogo; o.dur = duration; o.del = delay;
            o.hs = hard_stop; o.bsy = busy; o.dn = done; o.step = step_idx;
            tests++;
            if (o !== obs_t'(0)) begin
                fails++; $display("FAIL reset cyc %0d got %h exp %h", k, o, obs_t'(0));
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_step = '0;
    endtask

    task automatic test_single_entry();
        write_entry(0, 16'd5, 16'd2, 1'b1);
        chan_active = 8'h01; loop_count = 8'd0;
        set_off(2);
        off[0][0] = $urandom_range(8, 4);
        build_trace(passes_for(0));
        run_trace();
        for (int k = 1; k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k] !== exp_q[k]) begin
                fails++; $display("FAIL single_entry cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]);
            end
        end
        tests++;
        if (obs_q[3].go !== 1'b1 || obs_q[2].go !== 1'b0) begin
            fails++; $display("FAIL go_latency got %b%b exp 01", obs_q[2].go, obs_q[3].go);
        end
    endtask

    task automatic test_staggered();
        load_prog(3, 1'b1);
        chan_active = 8'hFF; loop_count = 8'd0;
        set_off(9);
        build_trace(passes_for(0));
        run_trace();
        for (int k = 1; k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k] !== exp_q[k]) begin
                fails++; $display("FAIL staggered cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            load_prog($urandom_range(5, 1), 1'b1);
            chan_active = (it == 0) ? '0 : NCH'($urandom);
            loop_count = 8'($urandom_range(1, 0));
            set_off(7);
            build_trace(passes_for(int'(loop_count)));
            run_trace();
            for (int k = 1; k < exp_q.size(); k++) begin
                tests++;
                if (obs_q[k] !== exp_q[k]) begin
                    fails++; $display("FAIL random%0d cyc %0d got %h exp %h", it, k, obs_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_depth_end();
        load_prog(DEPTH, 1'b0);
        chan_active = NCH'($urandom); loop_count = 8'd0;
        set_off(4);
        build_trace(passes_for(0));
        run_trace();
        for (int k = 1; k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k] !== exp_q[k]) begin
                fails++; $display("FAIL depth_end cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_loop();
        int gos;
        int dns;
        load_prog(2, 1'b1);
        chan_active = NCH'($urandom) | 8'h01; loop_count = 8'd2;
        set_off(5);
        build_trace(passes_for(2));
        run_trace();
        gos = 0; dns = 0;
        for (int k = 1; k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k] !== exp_q[k]) begin
                fails++; $display("FAIL loop cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]);
            end
            if (obs_q[k].go === 1'b1) gos++;
            if (obs_q[k].dn === 1'b1) dns++;
        end
        tests++;
`ifdef TRIG_SEQ_LOOP_EN
        if (gos !== 6) begin fails++; $display("FAIL loop_go_count got %0d exp 6", gos); end
`else
        if (gos !== 2) begin fails++; $display("FAIL loop_go_count got %0d exp 2", gos); end
`endif
        tests++;
        if (dns !== 1) begin fails++; $display("FAIL loop_done_count got %0d exp 1", dns); end
        loop_count = 8'd0;
    endtask

    task automatic test_abort();
        int a;
        load_prog(3, 1'b1);
        chan_active = 8'hFF; loop_count = 8'd0;
        set_off(6);
        build_trace(passes_for(0));
        a = 1 + (3 + wait_len(0) + 1) + 3 + 1;
        apply_abort(a);
        run_trace();
        for (int k = 1; k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k] !== exp_q[k]) begin
                fails++; $display("FAIL abort cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]);
            end
        end
        build_trace(passes_for(0));
        run_trace();
        for (int k = 1; k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k] !== exp_q[k]) begin
                fails++; $display("FAIL abort_rerun cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_start_abort();
        drv_t d;
        exp_q.delete(); drv_q.delete();
        for (int k = 0; k < 8; k++) begin
            d = rnd_drv();
            if (k == 0) begin d.start = 1'b1; d.abort = 1'b1; end
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, m_step)); drv_q.push_back(d);
        end
        run_trace();
        for (int k = 1; k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k] !== exp_q[k]) begin
                fails++; $display("FAIL start_abort cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        load_prog(3, 1'b1);
        chan_active = NCH'($urandom); loop_count = 8'd0;
        set_off(5);
        junk = 1'b1;
        build_trace(passes_for(0));
        run_trace();
        junk = 1'b0;
        for (int k = 1; k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k] !== exp_q[k]) begin
                fails++; $display("FAIL busy_start cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]);
            end
        end
        build_trace(passes_for(0));
        run_trace();
        for (int k = 1; k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k] !== exp_q[k]) begin
                fails++; $display("FAIL busy_write cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_rst_mid_run();
        load_prog(2, 1'b1);
        chan_active = NCH'($urandom); loop_count = 8'd0;
        set_off(5);
        build_trace(passes_for(0));
        apply_rst(3);
        run_trace();
        for (int k = 1; k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k] !== exp_q[k]) begin
                fails++; $display("FAIL rst_mid_run cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]);
            end
        end
        build_trace(passes_for(0));
        run_trace();
        for (int k = 1; k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k] !== exp_q[k]) begin
                fails++; $display("FAIL rst_rerun cyc %0d got %h exp %h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    initial begin
        tests = 0; fails = 0; junk = 1'b0; m_step = '0;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_duration = '0; wr_delay = '0; wr_last = 1'b0;
        start = 1'b0; abort = 1'b0; loop_count = '0; chan_active = '0; chan_complete = '0;
        test_reset();
        test_single_entry();
        test_staggered();
        test_random();
        test_depth_end();
        test_loop();
        test_abort();
        test_start_abort();
        test_busy_ignore();
        test_rst_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
